clock_set_ctrl: RTL and testbench

- Sequencing controller for the digital-clock counter chain (seconds/minutes 0-59 counters, hour counter).
- Generates the 1 Hz count enable from the system clock.
- Debounces the three front-panel keys and runs the RUN / SET_HOUR / SET_MIN / SET_SEC mode state machine.
- Issues single-cycle add/minus/clear commands to the counters, plus a blink enable for the display driver.

---
 rtl/clock_set_ctrl.sv | 152 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Mode/command sequencer for the digital-clock counter chain: 1 Hz prescaler,
// three debounced front-panel keys, RUN/SET mode FSM and display blink control.
module clock_set_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int DB_CYC    = 500000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_mode,
  input  logic       key_up,
  input  logic       key_down,
  output logic       sec_tick,
  output logic       sec_clr,
  output logic       min_add,
  output logic       min_minus,
  output logic       hour_add,
  output logic       hour_minus,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_e;

  localparam int CW = $clog2(DB_CYC + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYC - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // Key vectors are ordered {mode, up, down}.
  logic [2:0]    raw, sync1, sync2, level, level_d, level_dd, press;
  logic [CW-1:0] db_cnt [3];
  logic          mode_p, up_p, down_p;

  mode_e         state, state_next;
  logic [TW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          tick_n, sec_clr_n, min_add_n, min_minus_n, hour_add_n, hour_minus_n;

  assign raw    = {key_mode, key_up, key_down};
  assign mode_p = press[2];
  assign up_p   = press[1];
  assign down_p = press[0];
  assign mode   = state;

  // Two delay stages after acceptance give the press pulse its fixed DB_CYC+3 latency.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1    <= '0;
      sync2    <= '0;
      level    <= '0;
      level_d  <= '0;
      level_dd <= '0;
      press    <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1    <= raw;
      sync2    <= sync1;
      level_d  <= level;
      level_dd <= level_d;
      press    <= level_d & ~level_dd;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= RUN;
    else      state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_next   = state;
    sec_clr_n    = 1'b0;
    min_add_n    = 1'b0;
    min_minus_n  = 1'b0;
    hour_add_n   = 1'b0;
    hour_minus_n = 1'b0;
    if (mode_p) begin
      case (state)
        RUN:      state_next = SET_HOUR;
        SET_HOUR: state_next = SET_MIN;
        SET_MIN:  state_next = SET_SEC;
        SET_SEC:  state_next = RUN;
        default:  state_next = RUN;
      endcase
    end else if (up_p ^ down_p) begin
      case (state)
        SET_HOUR: begin hour_add_n = up_p; hour_minus_n = down_p; end
        SET_MIN:  begin min_add_n  = up_p; min_minus_n  = down_p; end
        SET_SEC:  sec_clr_n = 1'b1;
        default:  ;
      endcase
    end
    // A mode press out of RUN suppresses the tick so it never lands in a SET mode.
    tick_n = (state == RUN) && !mode_p && (presc == TICK_LAST);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sec_tick   <= 1'b0;
      sec_clr    <= 1'b0;
      min_add    <= 1'b0;
      min_minus  <= 1'b0;
      hour_add   <= 1'b0;
      hour_minus <= 1'b0;
      presc      <= '0;
      blink_cnt  <= '0;
      blink      <= 1'b0;
    end else begin
      sec_tick   <= tick_n;
      sec_clr    <= sec_clr_n;
      min_add    <= min_add_n;
      min_minus  <= min_minus_n;
      hour_add   <= hour_add_n;
      hour_minus <= hour_minus_n;

      if (state == RUN && state_next == RUN)
        presc <= (presc == TICK_LAST) ? '0 : presc + 1'b1;
      else
        presc <= '0;

      if (state_next != state || state == RUN) begin
        blink_cnt <= '0;
        blink     <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: stimulus queues expected output events,
// a negedge monitor pops and compares each pulse or mode change it observes.
module tb_clock_set_ctrl;

  localparam logic [5:0] P_NONE = 6'b000000;
  localparam logic [5:0] P_TICK = 6'b100000;
  localparam logic [5:0] P_SCLR = 6'b010000;
  localparam logic [5:0] P_MADD = 6'b001000;
  localparam logic [5:0] P_MMIN = 6'b000100;
  localparam logic [5:0] P_HADD = 6'b000010;
  localparam logic [5:0] P_HMIN = 6'b000001;

  localparam logic [2:0] K_MODE = 3'b100;
  localparam logic [2:0] K_UP   = 3'b010;
  localparam logic [2:0] K_DOWN = 3'b001;

  typedef struct {
    int         cyc;
    logic [5:0] p;
    logic [1:0] m;
  } ev_t;

  logic       clk, clr, key_mode, key_up, key_down;
  logic       sec_tick, sec_clr, min_add, min_minus, hour_add, hour_minus, blink;
  logic [1:0] mode;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  ev_t        sb[$];
  ev_t        e;
  logic [5:0] obs;
  logic [1:0] prev_mode = 2'd0;

  clock_set_ctrl #(.TICK_DIV(10), .DB_CYC(4), .BLINK_DIV(6)) dut (
    .clk        (clk),
    .clr        (clr),
    .key_mode   (key_mode),
    .key_up     (key_up),
    .key_down   (key_down),
    .sec_tick   (sec_tick),
    .sec_clr    (sec_clr),
    .min_add    (min_add),
    .min_minus  (min_minus),
    .hour_add   (hour_add),
    .hour_minus (hour_minus),
    .mode       (mode),
    .blink      (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [5:0] p, input logic [1:0] m);
    ev_t x;
    x.cyc = c;
    x.p   = p;
    x.m   = m;
    sb.push_back(x);
  endtask

  // Press/release a key combination; the first sampling edge is cyc+1 and
  // registered outputs appear DB_CYC+3+1 = 8 edges later, i.e. at cyc+9.
  task automatic hit(input logic [2:0] k, input logic [5:0] p, input logic [1:0] m,
                     input bit ev);
    int c;
    c = cyc;
    {key_mode, key_up, key_down} = k;
    if (ev) push(c + 9, p, m);
    if (ev && m == 2'd0) push(c + 19, P_TICK, 2'd0);
    repeat (6) @(negedge clk);
    {key_mode, key_up, key_down} = 3'b000;
    repeat (10) @(negedge clk);
  endtask

  always @(negedge clk) begin
    obs = {sec_tick, sec_clr, min_add, min_minus, hour_add, hour_minus};
    if (clr === 1'b1 && (obs != 6'd0 || mode != prev_mode)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: cyc=%0d pulses=%b mode=%0d, required no event",
                 cyc, obs, mode);
      end else begin
        e = sb.pop_front();
        check("ev_cyc", cyc, e.cyc);
        check("ev_pulses", {26'd0, obs}, {26'd0, e.p});
        check("ev_mode", {30'd0, mode}, {30'd0, e.m});
      end
    end
    prev_mode = mode;
  end

  initial begin
    int c0, c, r;
    clr = 1'b0;
    {key_mode, key_up, key_down} = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_mode", {30'd0, mode}, 0);
    check("rst_pulses", {26'd0, sec_tick, sec_clr, min_add, min_minus, hour_add, hour_minus}, 0);
    check("rst_blink", {31'd0, blink}, 0);

    // Idle RUN: ticks every TICK_DIV cycles after release.
    c0 = cyc;
    clr = 1'b1;
    for (int i = 1; i <= 4; i++) push(c0 + 10 * i, P_TICK, 2'd0);
    repeat (35) @(negedge clk);

    // Mode press into SET_HOUR with blink phase checked cycle by cycle.
    c = cyc;
    key_mode = 1'b1;
    push(c + 9, P_NONE, 2'd1);
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 10) key_mode = 1'b0;
      check("blink", {31'd0, blink}, (i < 9) ? 0 : (((i - 9) / 6) % 2));
    end

    hit(K_UP,   P_HADD, 2'd1, 1'b1);
    hit(K_DOWN, P_HMIN, 2'd1, 1'b1);
    hit(K_MODE, P_NONE, 2'd2, 1'b1);
    hit(K_UP,   P_MADD, 2'd2, 1'b1);
    hit(K_DOWN, P_MMIN, 2'd2, 1'b1);
    hit(K_MODE, P_NONE, 2'd3, 1'b1);
    hit(K_UP,   P_SCLR, 2'd3, 1'b1);
    hit(K_DOWN, P_SCLR, 2'd3, 1'b1);

    // Bouncing and a short glitch in SET_SEC must never produce sec_clr.
    for (int i = 0; i < 30; i++) begin
      key_up = ((i >> 1) & 1) != 0;
      @(negedge clk);
    end
    key_up = 1'b0;
    repeat (12) @(negedge clk);
    key_up = 1'b1;
    repeat (3) @(negedge clk);
    key_up = 1'b0;
    repeat (12) @(negedge clk);

    // Back round to SET_MIN, then simultaneous-key cases.
    hit(K_MODE, P_NONE, 2'd0, 1'b1);
    hit(K_MODE, P_NONE, 2'd1, 1'b1);
    hit(K_MODE, P_NONE, 2'd2, 1'b1);
    hit(K_UP | K_DOWN, P_NONE, 2'd2, 1'b0);
    hit(K_MODE | K_UP, P_NONE, 2'd3, 1'b1);
    hit(K_MODE, P_NONE, 2'd0, 1'b1);
    hit(K_MODE, P_NONE, 2'd1, 1'b1);
    hit(K_MODE, P_NONE, 2'd2, 1'b1);

    // Reset mid SET_MIN with key_up held across the reset.
    c = cyc;
    key_up = 1'b1;
    push(c + 9, P_MADD, 2'd2);
    repeat (12) @(negedge clk);
    clr = 1'b0;
    #1;
    check("clr_mode", {30'd0, mode}, 0);
    check("clr_blink", {31'd0, blink}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("clr_pulses", {26'd0, sec_tick, sec_clr, min_add, min_minus, hour_add, hour_minus}, 0);
      check("clr_mode_hold", {30'd0, mode}, 0);
    end
    r = cyc;
    clr = 1'b1;
    for (int i = 1; i <= 3; i++) push(r + 10 * i, P_TICK, 2'd0);
    repeat (12) @(negedge clk);
    key_up = 1'b0;
    repeat (10) @(negedge clk);
    hit(K_MODE, P_NONE, 2'd1, 1'b1);
    hit(K_MODE, P_NONE, 2'd2, 1'b1);
    hit(K_MODE, P_NONE, 2'd3, 1'b1);
    hit(K_MODE, P_NONE, 2'd0, 1'b1);
    repeat (5) @(negedge clk);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
